// File: rtl/input_pixel_queue.sv
// input_pixel_queue: first stage of the network pipeline.
// A binarized image arrives as a serial pixel stream. The index of every set
// pixel is queued in a circular FIFO. Layer 1 then pops the indices in
// ascending order through queueOut/dequeue/queueEmpty/inputsReady.
// A new image is accepted only after the previous image has fully drained.
//
// Handshake rules:
//   pixel side : a pixel transfers at a rising edge where pixelValid and
//                pixelReady are both 1. pixelReady is high only in LOAD.
//   queue side : a pop transfers at a rising edge where dequeue is 1 and
//                queueEmpty is 0, and only in DRAIN (inputsReady = 1).
//                queueOut is valid whenever queueEmpty is 0.
//                A dequeue at any other time has no effect.
// Every output is a flop, so no combinational path runs from an input to an
// output. The FSM state is visible outside the block: pixelReady is high in
// LOAD and inputsReady is high in DRAIN.
module input_pixel_queue #(
    parameter int PIXELS = 784,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pixelIn,
    input  logic              pixelValid,
    output logic              pixelReady,
    output logic              blankImage,
    output logic              inputsReady,
    output logic              queueEmpty,
    output logic [ADDR_W-1:0] queueOut,
    input  logic              dequeue,
    output logic [ADDR_W:0]   queueCount
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pix_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] mem [PIXELS];

    logic              accept;
    logic              push;
    logic              pop;
    logic              last_pixel;
    logic [ADDR_W-1:0] wr_next;
    logic [ADDR_W-1:0] rd_next;

    // Decode this cycle's transfers and the wrapped next-pointer values.
    always_comb begin
        accept     = (state == LOAD) && pixelValid;
        push       = accept && pixelIn;
        pop        = (state == DRAIN) && dequeue && !queueEmpty;
        last_pixel = accept && (pix_cnt == LAST_IDX);
        wr_next    = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
        rd_next    = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
    end

    // Storage array. It has no reset: an entry is read only after it is written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pix_cnt;
        end
    end

    // State machine with pointers, occupancy, and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= LOAD;
            pix_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queueCount  <= '0;
            queueEmpty  <= 1'b1;
            inputsReady <= 1'b0;
            pixelReady  <= 1'b1;
            blankImage  <= 1'b0;
            queueOut    <= '0;
        end else begin
            blankImage <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (push) begin
                            wr_ptr     <= wr_next;
                            queueCount <= queueCount + 1'b1;
                            queueEmpty <= 1'b0;
                            // The first entry of an image becomes the head at once.
                            if (queueEmpty) begin
                                queueOut <= pix_cnt;
                            end
                        end
                        if (last_pixel) begin
                            pix_cnt <= '0;
                            // LOAD always starts with an empty queue. A non-empty
                            // queue or a write on this edge means the image has
                            // at least one set pixel.
                            if (push || !queueEmpty) begin
                                state       <= DRAIN;
                                inputsReady <= 1'b1;
                                pixelReady  <= 1'b0;
                            end else begin
                                blankImage <= 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop) begin
                        rd_ptr     <= rd_next;
                        queueCount <= queueCount - 1'b1;
                        if (queueCount == COUNT_ONE) begin
                            queueEmpty  <= 1'b1;
                            state       <= LOAD;
                            inputsReady <= 1'b0;
                            pixelReady  <= 1'b1;
                        end else begin
                            // The next head is loaded on the same edge the pointer moves.
                            queueOut <= mem[rd_next];
                        end
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_input_pixel_queue.sv
// Directed bench for input_pixel_queue. Stimulus is driven one time unit
// after each rising edge. Outputs are sampled at the same point, so they
// show the result of the edge just taken.
module tb_input_pixel_queue;

    localparam int PIXELS = 784;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              pixelIn = 1'b0;
    logic              pixelValid = 1'b0;
    logic              pixelReady;
    logic              blankImage;
    logic              inputsReady;
    logic              queueEmpty;
    logic [ADDR_W-1:0] queueOut;
    logic              dequeue = 1'b0;
    logic [ADDR_W:0]   queueCount;

    int vectors = 0;
    int miscompares = 0;
    logic [ADDR_W-1:0] exp_q[$];

    input_pixel_queue #(.PIXELS(PIXELS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .pixelIn    (pixelIn),
        .pixelValid (pixelValid),
        .pixelReady (pixelReady),
        .blankImage (blankImage),
        .inputsReady(inputsReady),
        .queueEmpty (queueEmpty),
        .queueOut   (queueOut),
        .dequeue    (dequeue),
        .queueCount (queueCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed pixels first..last of img. Each set pixel adds its index to exp_q.
    task automatic feed_range(input logic [PIXELS-1:0] img, input int first,
                              input int last, input bit gaps);
        for (int p = first; p <= last; p++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                pixelValid = 1'b0;
                pixelIn    = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
            end
            pixelIn    = img[p];
            pixelValid = 1'b1;
            tick();
            if (img[p]) exp_q.push_back(ADDR_W'(p));
        end
        pixelValid = 1'b0;
        pixelIn    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL reset_pixelReady: got %b want 1", pixelReady); end
        vectors++; if (inputsReady !== 1'b0) begin miscompares++; $display("FAIL reset_inputsReady: got %b want 0", inputsReady); end
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL reset_queueEmpty: got %b want 1", queueEmpty); end
        vectors++; if (queueCount !== 11'd0) begin miscompares++; $display("FAIL reset_queueCount: got %0d want 0", queueCount); end
        vectors++; if (blankImage !== 1'b0) begin miscompares++; $display("FAIL reset_blankImage: got %b want 0", blankImage); end
        vectors++; if (queueOut !== 10'd0) begin miscompares++; $display("FAIL reset_queueOut: got %0d want 0", queueOut); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_blank_image();
        logic [PIXELS-1:0] img = '0;
        exp_q.delete();
        feed_range(img, 0, PIXELS - 2, 1'b0);
        vectors++; if (blankImage !== 1'b0) begin miscompares++; $display("FAIL blank_early: got %b want 0", blankImage); end
        feed_range(img, PIXELS - 1, PIXELS - 1, 1'b0);
        vectors++; if (blankImage !== 1'b1) begin miscompares++; $display("FAIL blank_pulse: got %b want 1", blankImage); end
        vectors++; if (inputsReady !== 1'b0) begin miscompares++; $display("FAIL blank_inputsReady: got %b want 0", inputsReady); end
        vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL blank_pixelReady: got %b want 1", pixelReady); end
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL blank_queueEmpty: got %b want 1", queueEmpty); end
        tick();
        vectors++; if (blankImage !== 1'b0) begin miscompares++; $display("FAIL blank_one_cycle: got %b want 0", blankImage); end
    endtask

    task automatic test_three_pixels();
        logic [PIXELS-1:0] img = '0;
        img[0] = 1'b1; img[5] = 1'b1; img[783] = 1'b1;
        exp_q.delete();
        feed_range(img, 0, PIXELS - 1, 1'b0);
        vectors++; if (inputsReady !== 1'b1) begin miscompares++; $display("FAIL three_inputsReady: got %b want 1", inputsReady); end
        vectors++; if (queueCount !== 11'd3) begin miscompares++; $display("FAIL three_count: got %0d want 3", queueCount); end
        vectors++; if (queueOut !== 10'd0) begin miscompares++; $display("FAIL three_head0: got %0d want 0", queueOut); end
        vectors++; if (pixelReady !== 1'b0) begin miscompares++; $display("FAIL three_pixelReady: got %b want 0", pixelReady); end
        // Pixels offered during DRAIN must be ignored.
        pixelIn = 1'b1; pixelValid = 1'b1;
        repeat (5) tick();
        pixelValid = 1'b0; pixelIn = 1'b0;
        vectors++; if (queueCount !== 11'd3) begin miscompares++; $display("FAIL drain_ignore_count: got %0d want 3", queueCount); end
        vectors++; if (queueOut !== 10'd0) begin miscompares++; $display("FAIL drain_ignore_head: got %0d want 0", queueOut); end
        dequeue = 1'b1;
        tick();
        vectors++; if (queueOut !== 10'd5) begin miscompares++; $display("FAIL three_head1: got %0d want 5", queueOut); end
        vectors++; if (queueCount !== 11'd2) begin miscompares++; $display("FAIL three_count1: got %0d want 2", queueCount); end
        tick();
        vectors++; if (queueOut !== 10'd783) begin miscompares++; $display("FAIL three_head2: got %0d want 783", queueOut); end
        tick();
        dequeue = 1'b0;
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL three_empty: got %b want 1", queueEmpty); end
        vectors++; if (queueCount !== 11'd0) begin miscompares++; $display("FAIL three_count_end: got %0d want 0", queueCount); end
        vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL three_pixelReady_end: got %b want 1", pixelReady); end
        vectors++; if (inputsReady !== 1'b0) begin miscompares++; $display("FAIL three_inputsReady_end: got %b want 0", inputsReady); end
    endtask

    // Two all-ones images. Pointers start at 3 here, so both images wrap the buffer.
    task automatic test_full_image();
        logic [PIXELS-1:0] img = '1;
        for (int pass = 0; pass < 2; pass++) begin
            exp_q.delete();
            feed_range(img, 0, PIXELS - 1, 1'b0);
            vectors++; if (queueCount !== 11'd784) begin miscompares++; $display("FAIL full_count pass %0d: got %0d want 784", pass, queueCount); end
            vectors++; if (inputsReady !== 1'b1) begin miscompares++; $display("FAIL full_inputsReady pass %0d: got %b want 1", pass, inputsReady); end
            dequeue = 1'b1;
            for (int i = 0; i < PIXELS; i++) begin
                vectors++; if (queueOut !== ADDR_W'(i)) begin miscompares++; $display("FAIL full_order pass %0d: got %0d want %0d", pass, queueOut, i); end
                tick();
            end
            dequeue = 1'b0;
            vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL full_empty pass %0d: got %b want 1", pass, queueEmpty); end
            vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL full_pixelReady pass %0d: got %b want 1", pass, pixelReady); end
        end
    endtask

    task automatic test_gaps();
        logic [PIXELS-1:0] img = '0;
        int guard = 0;
        for (int i = 0; i < 50; i++) img[i * 15 + 7] = 1'b1;
        exp_q.delete();
        // A dequeue while the queue is empty has no effect.
        dequeue = 1'b1;
        repeat (3) tick();
        dequeue = 1'b0;
        vectors++; if (queueCount !== 11'd0) begin miscompares++; $display("FAIL gaps_deq_empty_count: got %0d want 0", queueCount); end
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL gaps_deq_empty_flag: got %b want 1", queueEmpty); end
        feed_range(img, 0, 399, 1'b1);
        // A dequeue during LOAD has no effect, even with entries queued.
        dequeue = 1'b1;
        repeat (2) tick();
        dequeue = 1'b0;
        vectors++; if (queueCount !== 11'(exp_q.size())) begin miscompares++; $display("FAIL gaps_deq_load: got %0d want %0d", queueCount, exp_q.size()); end
        feed_range(img, 400, PIXELS - 1, 1'b1);
        vectors++; if (queueCount !== 11'd50) begin miscompares++; $display("FAIL gaps_count: got %0d want 50", queueCount); end
        vectors++; if (inputsReady !== 1'b1) begin miscompares++; $display("FAIL gaps_inputsReady: got %b want 1", inputsReady); end
        while (exp_q.size() > 0 && guard < 2000) begin
            guard++;
            vectors++; if (queueCount !== 11'(exp_q.size())) begin miscompares++; $display("FAIL gaps_drain_count: got %0d want %0d", queueCount, exp_q.size()); end
            if ($urandom_range(0, 1) == 1) begin
                vectors++; if (queueOut !== exp_q[0]) begin miscompares++; $display("FAIL gaps_order: got %0d want %0d", queueOut, exp_q[0]); end
                void'(exp_q.pop_front());
                dequeue = 1'b1;
            end else begin
                dequeue = 1'b0;
            end
            tick();
        end
        dequeue = 1'b0;
        vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL gaps_drain_timeout: got %0d left want 0", exp_q.size()); end
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL gaps_empty: got %b want 1", queueEmpty); end
        vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL gaps_pixelReady: got %b want 1", pixelReady); end
    endtask

    task automatic test_reset_midload();
        logic [PIXELS-1:0] img = '0;
        logic [PIXELS-1:0] img2 = '0;
        img[3] = 1'b1; img[100] = 1'b1; img[399] = 1'b1;
        img2[10] = 1'b1;
        exp_q.delete();
        feed_range(img, 0, 399, 1'b0);
        reset = 1'b0;
        #2;
        vectors++; if (queueCount !== 11'd0) begin miscompares++; $display("FAIL midload_rst_count: got %0d want 0", queueCount); end
        vectors++; if (queueEmpty !== 1'b1) begin miscompares++; $display("FAIL midload_rst_empty: got %b want 1", queueEmpty); end
        vectors++; if (pixelReady !== 1'b1) begin miscompares++; $display("FAIL midload_rst_pixelReady: got %b want 1", pixelReady); end
        repeat (2) tick();
        reset = 1'b1;
        tick();
        exp_q.delete();
        feed_range(img2, 0, PIXELS - 1, 1'b0);
        vectors++; if (inputsReady !== 1'b1) begin miscompares++; $display("FAIL after_rst_inputsReady: got %b want 1", inputsReady); end
        vectors++; if (queueCount !== 11'd1) begin miscompares++; $display("FAIL after_rst_count: got %0d want 1", queueCount); end
        vectors++; if (queueOut !== 10'd10) begin miscompares++; $display("FAIL after_rst_head: got %0d want 10", queueOut); end
        // A reset in the middle of DRAIN discards the queued entry.
        reset = 1'b0;
        #2;
        vectors++; if (inputsReady !== 1'b0) begin miscompares++; $display("FAIL middrain_rst_inputsReady: got %b want 0", inputsReady); end
        vectors++; if (queueCount !== 11'd0) begin miscompares++; $display("FAIL middrain_rst_count: got %0d want 0", queueCount); end
        vectors++; if (queueOut !== 10'd0) begin miscompares++; $display("FAIL middrain_rst_head: got %0d want 0", queueOut); end
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_blank_image();
        test_three_pixels();
        test_full_image();
        test_gaps();
        test_reset_midload();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
